// File: rtl/line_raster_engine.sv
// Bresenham line rasteriser and screen-clear engine, one framebuffer write per cycle.
// Optional CLIP_EN: off-screen line pixels are stepped through without being written.
module line_raster_engine #(
  parameter int COORD_W  = 11,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int COLOUR_W = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                clear,
  input  logic [COORD_W-1:0]  x0,
  input  logic [COORD_W-1:0]  y0,
  input  logic [COORD_W-1:0]  x1,
  input  logic [COORD_W-1:0]  y1,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                pixel_ready,
  output logic [COORD_W-1:0]  x,
  output logic [COORD_W-1:0]  y,
  output logic [COLOUR_W-1:0] colour,
  output logic                pixel_valid,
  output logic                done
);

  localparam int S = COORD_W + 2;
  typedef logic [COORD_W-1:0] crd_t;
  localparam crd_t XL = crd_t'(SCREEN_W - 1);
  localparam crd_t YL = crd_t'(SCREEN_H - 1);

  typedef enum logic [2:0] {IDLE, SETUP, LINE, CLEAR, DONE} state_e;

  state_e              state_q, state_d;
  logic                clr_q, clr_d;
  crd_t                ax0_q, ax0_d, ay0_q, ay0_d;
  crd_t                ax1_q, ax1_d, ay1_q, ay1_d;
  logic [COLOUR_W-1:0] col_q, col_d;
  logic                steep_q, steep_d;
  logic                neg_q, neg_d;
  crd_t                maj_q, maj_d, min_q, min_d;
  crd_t                end_q, end_d;
  crd_t                dx_q, dx_d, dy_q, dy_d;
  logic signed [S-1:0] err_q, err_d;

  logic signed [S-1:0] ddx, ddy, adx, ady, e2;
  logic                steep_s, swp;
  crd_t                a0, a1, b0, b1, ma0, ma1, mb0, mb1;
  crd_t                px, py;
  logic                adv, last_line, last_clr;

  // Endpoint normalisation: major axis chosen, then run in increasing order
  always_comb begin
    ddx     = $signed({2'b00, ax1_q}) - $signed({2'b00, ax0_q});
    ddy     = $signed({2'b00, ay1_q}) - $signed({2'b00, ay0_q});
    adx     = ddx[S-1] ? -ddx : ddx;
    ady     = ddy[S-1] ? -ddy : ddy;
    steep_s = ady > adx;
    a0      = steep_s ? ay0_q : ax0_q;
    a1      = steep_s ? ay1_q : ax1_q;
    b0      = steep_s ? ax0_q : ay0_q;
    b1      = steep_s ? ax1_q : ay1_q;
    swp     = a0 > a1;
    ma0     = swp ? a1 : a0;
    ma1     = swp ? a0 : a1;
    mb0     = swp ? b1 : b0;
    mb1     = swp ? b0 : b1;
  end

  assign px        = steep_q ? min_q : maj_q;
  assign py        = steep_q ? maj_q : min_q;
  assign e2        = err_q + $signed({2'b00, dy_q});
  assign last_line = maj_q == end_q;
  assign last_clr  = (maj_q == XL) && (min_q == YL);

`ifdef CLIP_EN
  logic off;
  assign off = (px >= crd_t'(SCREEN_W)) || (py >= crd_t'(SCREEN_H));
  assign adv = (pixel_valid & pixel_ready) | ((state_q == LINE) & off);
`else
  assign adv = pixel_valid & pixel_ready;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      clr_q   <= 1'b0;
      ax0_q   <= '0;
      ay0_q   <= '0;
      ax1_q   <= '0;
      ay1_q   <= '0;
      col_q   <= '0;
      steep_q <= 1'b0;
      neg_q   <= 1'b0;
      maj_q   <= '0;
      min_q   <= '0;
      end_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      ax0_q   <= ax0_d;
      ay0_q   <= ay0_d;
      ax1_q   <= ax1_d;
      ay1_q   <= ay1_d;
      col_q   <= col_d;
      steep_q <= steep_d;
      neg_q   <= neg_d;
      maj_q   <= maj_d;
      min_q   <= min_d;
      end_q   <= end_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   state_d = clr_q ? CLEAR : LINE;
      LINE:    if (adv && last_line) state_d = DONE;
      CLEAR:   if (adv && last_clr) state_d = DONE;
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clr_d   = clr_q;
    ax0_d   = ax0_q;
    ay0_d   = ay0_q;
    ax1_d   = ax1_q;
    ay1_d   = ay1_q;
    col_d   = col_q;
    steep_d = steep_q;
    neg_d   = neg_q;
    maj_d   = maj_q;
    min_d   = min_q;
    end_d   = end_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (start) begin
        clr_d = clear;
        ax0_d = x0;
        ay0_d = y0;
        ax1_d = x1;
        ay1_d = y1;
        col_d = colour_in;
      end
      SETUP: if (clr_q) begin
        steep_d = 1'b0;
        maj_d   = '0;
        min_d   = '0;
      end else begin
        steep_d = steep_s;
        neg_d   = mb1 < mb0;
        maj_d   = ma0;
        min_d   = mb0;
        end_d   = ma1;
        dx_d    = ma1 - ma0;
        dy_d    = (mb1 < mb0) ? mb0 - mb1 : mb1 - mb0;
        err_d   = '0 - $signed({3'b000, dx_d[COORD_W-1:1]});
      end
      LINE: if (adv && !last_line) begin
        maj_d = maj_q + crd_t'(1);
        if (!e2[S-1]) begin
          min_d = neg_q ? min_q - crd_t'(1) : min_q + crd_t'(1);
          err_d = e2 - $signed({2'b00, dx_q});
        end else begin
          err_d = e2;
        end
      end
      CLEAR: if (adv && !last_clr) begin
        if (maj_q == XL) begin
          maj_d = '0;
          min_d = min_q + crd_t'(1);
        end else begin
          maj_d = maj_q + crd_t'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    x           = '0;
    y           = '0;
    colour      = '0;
    pixel_valid = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      LINE: begin
        x      = px;
        y      = py;
        colour = col_q;
`ifdef CLIP_EN
        pixel_valid = !off;
`else
        pixel_valid = 1'b1;
`endif
      end
      CLEAR: begin
        x           = maj_q;
        y           = min_q;
        pixel_valid = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_line_raster_engine.sv
// Directed self-checking bench for line_raster_engine.
// Define CLIP_EN here too when the DUT is built with clipping.
module tb_line_raster_engine;

  logic        clk = 1'b0;
  logic        reset, start, clear, pixel_ready;
  logic [10:0] x0, y0, x1, y1, x, y;
  logic [0:0]  colour_in, colour;
  logic        pixel_valid, done;

  int n_chk  = 0;
  int n_fail = 0;
  int stall_bad;
  int wx[$], wy[$], wc[$], wk[$], ref_k[$], fwd_k[$];

  line_raster_engine dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .colour_in(colour_in),
    .pixel_ready(pixel_ready), .x(x), .y(y), .colour(colour),
    .pixel_valid(pixel_valid), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int set_diff(input int a[$], input int b[$]);
    int sa[$], sb[$], d;
    sa = a;
    sb = b;
    sa.sort();
    sb.sort();
    d = (sa.size() > sb.size()) ? sa.size() - sb.size() : sb.size() - sa.size();
    for (int i = 0; i < sa.size() && i < sb.size(); i++)
      if (sa[i] != sb[i]) d++;
    return d;
  endfunction

  // mode 0: ready=1, 1: ready toggles 1,0, 2: start dropped after launch
  task automatic run_op(input int ax, input int ay, input int bx, input int by,
                        input bit cl, input bit col, input int mode,
                        input int abort_at, input bit hold, output int cyc);
    bit fin, pst;
    logic [10:0] px, py;
    logic [0:0] pc;
    wx.delete(); wy.delete(); wc.delete(); wk.delete();
    stall_bad = 0;
    pst = 0;
    fin = 0;
    px = '0; py = '0; pc = '0;
    @(negedge clk);
    x0 = 11'(ax); y0 = 11'(ay); x1 = 11'(bx); y1 = 11'(by);
    clear = cl; colour_in = col; pixel_ready = 1'b1; start = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (!fin) begin
      @(negedge clk);
      if (mode == 2) start = 1'b0;
      if (done) begin
        fin = 1;
      end else if (cyc > 80000) begin
        check("timeout", cyc, 0);
        fin = 1;
      end else begin
        if (pst && (x !== px || y !== py || colour !== pc || !pixel_valid))
          stall_bad++;
        pixel_ready = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
        #1;
        if (pixel_valid && pixel_ready) begin
          wx.push_back(int'(x)); wy.push_back(int'(y));
          wc.push_back(int'(colour)); wk.push_back(int'(x) * 4096 + int'(y));
        end
        pst = pixel_valid && !pixel_ready;
        px = x; py = y; pc = colour;
        if (abort_at != 0 && wk.size() == abort_at) begin
          reset = 1'b1;
          @(posedge clk);
          #1;
          check("abort_valid", pixel_valid, 0);
          check("abort_done", done, 0);
          reset = 1'b0;
          start = 1'b0;
          fin = 1;
        end else begin
          @(posedge clk);
          cyc++;
        end
      end
    end
    if (!hold) start = 1'b0;
  endtask

  initial begin
    int cyc, bad;
    reset = 1'b1; start = 1'b0; clear = 1'b0; pixel_ready = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; colour_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_colour", colour, 0);
    check("rst_valid", pixel_valid, 0);
    check("rst_done", done, 0);
    reset = 1'b0;

    // vertical line
    run_op(50, 50, 50, 150, 0, 1, 0, 0, 0, cyc);
    check("t1_count", wk.size(), 101);
    check("t1_cycles", cyc, 102);
    bad = 0;
    foreach (wx[i]) if (wx[i] != 50 || wy[i] != 50 + i || wc[i] != 1) bad++;
    check("t1_pixels", bad, 0);
    @(negedge clk);
    check("t1_done_pulse", done, 0);

    // full diagonal, both directions
    run_op(0, 0, 319, 239, 0, 1, 0, 0, 0, cyc);
    check("t2_count", wk.size(), 320);
    check("t2_first", wk[0], 0);
    check("t2_last", wk[wk.size()-1], 319 * 4096 + 239);
    bad = 0;
    foreach (wx[i]) begin
      if (wx[i] != i) bad++;
      if (i > 0 && wy[i] < wy[i-1]) bad++;
    end
    check("t2_order", bad, 0);
    fwd_k = wk;
    run_op(319, 239, 0, 0, 0, 1, 0, 0, 0, cyc);
    check("t2r_count", wk.size(), 320);
    check("t2r_set", set_diff(wk, fwd_k), 0);

    // screen clear; endpoints and colour must be ignored
    run_op(7, 9, 100, 3, 1, 1, 0, 0, 0, cyc);
    check("t3_count", wk.size(), 76800);
    check("t3_cycles", cyc, 76801);
    bad = 0;
    foreach (wx[i]) if (wx[i] != i % 320 || wy[i] != i / 320 || wc[i] != 0) bad++;
    check("t3_raster", bad, 0);
    check("t3_last", wk[wk.size()-1], 319 * 4096 + 239);

    // backpressure
    run_op(200, 100, 0, 210, 0, 1, 0, 0, 0, cyc);
    check("t4_ref_count", wk.size(), 201);
    check("t4_ref_cycles", cyc, 202);
    ref_k = wk;
    run_op(200, 100, 0, 210, 0, 1, 1, 0, 0, cyc);
    check("t4_count", wk.size(), 201);
    check("t4_stall_stable", stall_bad, 0);
    check("t4_set", set_diff(wk, ref_k), 0);

    // reset mid-line, then a single point
    run_op(0, 0, 30, 10, 0, 1, 0, 10, 0, cyc);
    run_op(5, 5, 5, 5, 0, 1, 0, 0, 0, cyc);
    check("t5_count", wk.size(), 1);
    check("t5_pixel", wk[0], 5 * 4096 + 5);
    check("t5_cycles", cyc, 2);

    // horizontal line crossing the right edge
    run_op(300, 100, 340, 100, 0, 1, 0, 0, 0, cyc);
`ifdef CLIP_EN
    check("t6_count", wk.size(), 20);
    check("t6_last_x", wx[wx.size()-1], 319);
`else
    check("t6_count", wk.size(), 41);
    check("t6_last_x", wx[wx.size()-1], 340);
`endif
    check("t6_first_x", wx[0], 300);
    check("t6_cycles", cyc, 42);

    // start held through DONE: no relaunch
    run_op(10, 10, 12, 11, 0, 1, 0, 0, 1, cyc);
    check("t7_count", wk.size(), 3);
    repeat (3) begin
      @(negedge clk);
      check("t7_done_held", done, 1);
      check("t7_no_write", pixel_valid, 0);
    end
    start = 1'b0;
    @(negedge clk);
    check("t7_done_drop", done, 0);
    @(negedge clk);
    check("t7_idle_valid", pixel_valid, 0);

    // start dropped right after launch: completes, done pulses once
    run_op(0, 0, 3, 0, 0, 1, 2, 0, 0, cyc);
    check("t8_count", wk.size(), 4);
    check("t8_cycles", cyc, 5);
    @(negedge clk);
    check("t8_done_pulse", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
